rs_hs_relay_pipeline: RTL



---
 rtl/rs_hs_relay_pipeline.sv | 114 +++++++++++
 1 files changed

// File: rtl/rs_hs_relay_pipeline.sv
// Purpose: register-pipelined stream relay for channels that cross slot/region boundaries.
// Latency: an accepted word is visible at if_empty_n/if_dout LEVEL+1 cycles later when the FIFO is empty.
// Backpressure: almost-full credit returns through LEVEL stages; the tail FIFO holds every in-flight word.
module rs_hs_relay_pipeline #(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL      = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read
);

  // Round trip of the credit loop: words accepted after the FIFO crosses the
  // threshold but before the deasserted credit reaches the head.
  localparam int GRACE = 2*LEVEL + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(FIFO_DEPTH - GRACE);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  if (FIFO_DEPTH < 2*LEVEL + 2) begin : g_depth_check
    $error("rs_hs_relay_pipeline: FIFO_DEPTH must be >= 2*LEVEL+2");
  end

  logic                  accept;
  logic                  pop;
  logic                  almost_full_n;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_wdat;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // if_full_n and if_empty_n come from registers only, so these never loop
  // back combinationally across the region boundary.
  assign accept        = if_write & if_full_n;
  assign pop           = if_read & if_empty_n;
  assign almost_full_n = (count < THRESH);
  assign if_empty_n    = (count != '0);
  assign if_dout       = mem[rd_ptr];

  if (LEVEL == 0) begin : g_direct
    assign fifo_wr   = accept;
    assign fifo_wdat = if_din;
    assign if_full_n = almost_full_n;
  end else begin : g_pipe
    logic [LEVEL-1:0]      fwd_vld;
    logic [DATA_WIDTH-1:0] fwd_dat [LEVEL];
    logic [LEVEL-1:0]      bwd_rdy;

    // Forward data and backward credit shift one stage per cycle, never stalling.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fwd_vld <= '0;
        bwd_rdy <= '0;
        for (int k = 0; k < LEVEL; k++) begin
          fwd_dat[k] <= '0;
        end
      end else begin
        fwd_vld[0] <= accept;
        fwd_dat[0] <= if_din;
        bwd_rdy[0] <= almost_full_n;
        for (int k = 1; k < LEVEL; k++) begin
          fwd_vld[k] <= fwd_vld[k-1];
          fwd_dat[k] <= fwd_dat[k-1];
          bwd_rdy[k] <= bwd_rdy[k-1];
        end
      end
    end

    assign fifo_wr   = fwd_vld[LEVEL-1];
    assign fifo_wdat = fwd_dat[LEVEL-1];
    assign if_full_n = bwd_rdy[LEVEL-1];
  end

  // Tail FIFO: circular buffer with explicit wrap so any depth works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (fifo_wr) begin
        mem[wr_ptr] <= fifo_wdat;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (fifo_wr && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!fifo_wr && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // The credit slack makes a write into a full FIFO impossible; flag it if it ever happens.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && (count == CNT_FULL)));

endmodule
